cordic_vec_angle_seq: RTL

//  Sequential angle accumulator for an iterative (one micro-rotation per accepted beat) CORDIC vectoring core.

---
 rtl/cordic_vec_angle_seq_if.sv | 27 ++
 rtl/cordic_vec_angle_seq.sv | 126 ++++++++++++
 2 files changed

// File: rtl/cordic_vec_angle_seq_if.sv
// Handshake bundle between the iterative CORDIC direction source, the angle
// accumulator and the angle consumer.
interface cordic_vec_angle_seq_if #(
  parameter int ANGLE_WIDTH = 16
);
  logic                   start_in;
  logic [1:0]             quad_in;
  logic                   ready_out;
  logic                   dir_vld_in;
  logic                   dir_in;
  logic [ANGLE_WIDTH-1:0] angle_out;
  logic                   angle_vld_out;
  logic                   angle_rdy_in;
  logic                   err_out;

  // Accumulator side
  modport slave (
    input  start_in, quad_in, dir_vld_in, dir_in, angle_rdy_in,
    output ready_out, angle_out, angle_vld_out, err_out
  );

  // Driver/consumer side
  modport master (
    output start_in, quad_in, dir_vld_in, dir_in, angle_rdy_in,
    input  ready_out, angle_out, angle_vld_out, err_out
  );
endinterface

// File: rtl/cordic_vec_angle_seq.sv
// Sequential CORDIC vectoring angle accumulator: one +/-atan(2^-k) step per
// accepted direction beat, quadrant correction on the final stage, held
// output with backpressure and a sticky protocol-error flag.
module cordic_vec_angle_seq #(
  parameter int ANGLE_WIDTH   = 16,
  parameter int CORDIC_STAGES = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  cordic_vec_angle_seq_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

  localparam int KW = 6;
  localparam logic [KW-1:0] LAST = KW'(CORDIC_STAGES - 1);
  localparam logic [ANGLE_WIDTH-1:0] PI = {1'b1, {(ANGLE_WIDTH-1){1'b0}}};

  // floor(atan(2^-k)/pi * 2^31); narrower angles take the top bits.
  localparam logic [31:0] ATAN32 [32] = '{
    32'h20000000, 32'h12E4051D, 32'h09FB385B, 32'h051111D4,
    32'h028B0D43, 32'h0145D7E1, 32'h00A2F61E, 32'h00517C55,
    32'h0028BE53, 32'h00145F2E, 32'h000A2F98, 32'h000517CC,
    32'h00028BE6, 32'h000145F3, 32'h0000A2F9, 32'h0000517C,
    32'h000028BE, 32'h0000145F, 32'h00000A2F, 32'h00000517,
    32'h0000028B, 32'h00000145, 32'h000000A2, 32'h00000051,
    32'h00000028, 32'h00000014, 32'h0000000A, 32'h00000005,
    32'h00000002, 32'h00000001, 32'h00000000, 32'h00000000
  };

  state_t                 state_q, state_d;
  logic [ANGLE_WIDTH-1:0] z_q, z_d;
  logic [KW-1:0]          k_q, k_d;
  logic [1:0]             quad_q, quad_d;
  logic [ANGLE_WIDTH-1:0] angle_q, angle_d;
  logic                   vld_q, vld_d;
  logic                   err_q, err_d;
  logic [ANGLE_WIDTH-1:0] atan_k, t;

  // Map the accumulated first-quadrant angle back into the input quadrant.
  function automatic logic [ANGLE_WIDTH-1:0] fix(input logic [1:0] q,
                                                 input logic [ANGLE_WIDTH-1:0] a);
    case (q)
      2'b00:   fix = a;
      2'b01:   fix = PI - a;
      2'b11:   fix = PI + a;
      default: fix = -a;
    endcase
  endfunction

  // Current stage's atan step and the tentative next angle.
  always_comb begin
    atan_k = '0;
    if (k_q < KW'(32))
      atan_k = ANGLE_WIDTH'(ATAN32[k_q[4:0]] >> (32 - ANGLE_WIDTH));
    t = bus.dir_in ? (z_q - atan_k) : (z_q + atan_k);
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    z_d     = z_q;
    k_d     = k_q;
    quad_d  = quad_q;
    angle_d = angle_q;
    vld_d   = vld_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (bus.dir_vld_in) err_d = 1'b1;
        if (bus.start_in) begin
          z_d     = '0;
          k_d     = '0;
          quad_d  = bus.quad_in;
          state_d = ACC;
        end
      end
      ACC: begin
        if (bus.start_in) err_d = 1'b1;
        if (bus.dir_vld_in) begin
          if (k_q == LAST) begin
            angle_d = fix(quad_q, t);
            vld_d   = 1'b1;
            state_d = OUT;
          end else begin
            z_d = t;
            k_d = k_q + 1'b1;
          end
        end
      end
      OUT: begin
        if (bus.dir_vld_in || bus.start_in) err_d = 1'b1;
        if (bus.angle_rdy_in) begin
          vld_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      z_q     <= '0;
      k_q     <= '0;
      quad_q  <= '0;
      angle_q <= '0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      z_q     <= z_d;
      k_q     <= k_d;
      quad_q  <= quad_d;
      angle_q <= angle_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
    end
  end

  assign bus.ready_out     = (state_q == IDLE) && !reset;
  assign bus.angle_out     = angle_q;
  assign bus.angle_vld_out = vld_q;
  assign bus.err_out       = err_q;
endmodule
